// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction fetch stage. Holds the program counter and issues one word read at a
//   time to instruction memory. Returned words are buffered with their PCs in a small
//   FIFO whose head is presented to decode through a valid/ready handshake. A redirect
//   from execute flushes the buffer and restarts fetch at the new PC. A response that is
//   still in flight when the redirect arrives is discarded when it returns.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   in_redirect     load in_redirect_pc (word aligned) and flush buffered words
//   in_redirect_pc  redirect target, bits [1:0] ignored
//   out_imem_req    one-cycle read strobe, out_imem_addr valid with it
//   in_imem_rvalid  read data strobe, in_imem_rdata valid with it
//   out_valid       out_is/out_pc hold the FIFO head
//   in_ready        decode consumes the head this cycle
//   out_is, out_pc  head instruction word and its PC (zero when empty)

module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_redirect,
   input  logic [31:0] in_redirect_pc,
   output logic        out_imem_req,
   output logic [31:0] out_imem_addr,
   input  logic        in_imem_rvalid,
   input  logic [31:0] in_imem_rdata,
   output logic        out_valid,
   input  logic        in_ready,
   output logic [31:0] out_is,
   output logic [31:0] out_pc
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   // IDLE: nothing outstanding; WAIT: response will be kept; KILL: response will be dropped
   typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;

   state_t            state_reg, state_next;
   logic [31:0]       pc_reg;
   logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [31:0]       fifo_is_reg [FIFO_DEPTH];
   logic [31:0]       fifo_pc_reg [FIFO_DEPTH];

   logic imem_req;
   logic push;
   logic pop;
   logic redirect_pc_unused;

   assign redirect_pc_unused = ^in_redirect_pc[1:0];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   // A redirect in IDLE never issues a request, so IDLE stays IDLE. A response always
   // closes the outstanding request; only its fate (keep/drop) depends on the state.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE: begin
            if (imem_req) state_next = WAIT;
         end
         WAIT: begin
            if (in_imem_rvalid)   state_next = IDLE;
            else if (in_redirect) state_next = KILL;
         end
         KILL: begin
            if (in_imem_rvalid) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // The request depends only on registered state/count plus redirect and reset,
   // never on in_ready or the memory response.
   always_comb begin
      imem_req = 1'b0;
      push     = 1'b0;
      unique case (state_reg)
         IDLE:    imem_req = !in_redirect && (count_reg < DEPTH_CNT) && !rst;
         WAIT:    push     = in_imem_rvalid && !in_redirect;
         default: begin
         end
      endcase
   end

   assign out_imem_req  = imem_req;
   assign out_imem_addr = pc_reg;

   // ---------------- PC and FIFO bookkeeping ----------------
   assign out_valid = (count_reg != '0);
   assign pop       = out_valid && in_ready && !in_redirect;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg     <= RESET_PC;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (in_redirect) begin
         // Flush wins over any push/pop this cycle; pc only advances on kept words.
         pc_reg     <= {in_redirect_pc[31:2], 2'b00};
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            pc_reg     <= pc_reg + 32'd4;
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         unique case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero whenever count is zero.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         fifo_is_reg[wr_ptr_reg] <= in_imem_rdata;
         fifo_pc_reg[wr_ptr_reg] <= pc_reg;
      end
   end

   assign out_is = out_valid ? fifo_is_reg[rd_ptr_reg] : 32'h0;
   assign out_pc = out_valid ? fifo_pc_reg[rd_ptr_reg] : 32'h0;

endmodule
